// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared definitions for the divider sequencing controller.
//   state_e        controller state encoding
//   DIV_W          default operand/result width
//   QUO_*/REM_*    field positions inside the 2*DIV_W divider result word
package div_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    localparam int DIV_W = 32;

    // Divider IPs return {quotient, remainder}.
    localparam int QUO_MSB = 2 * DIV_W - 1;
    localparam int QUO_LSB = DIV_W;
    localparam int REM_MSB = DIV_W - 1;
    localparam int REM_LSB = 0;

endpackage

// File: rtl/div_chan_hs.sv
// div_chan_hs: valid/ready handshake tracker for one divider input channel.
//   start   new operation accepted; clears the sent flag
//   active  controller is in a state that may present this channel
//   tready  selected IP's ready for this channel
//   tvalid  channel valid (active and not yet sent)
//   sent    handshake already completed for this operation
//   fire    handshake completing this cycle
module div_chan_hs (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    input  logic tready,
    output logic tvalid,
    output logic sent,
    output logic fire
);

    logic sent_q, sent_d;

    assign tvalid = active && !sent_q;
    assign fire   = tvalid && tready;
    assign sent   = sent_q;

    always_comb begin
        sent_d = sent_q;
        if (start)
            sent_d = 1'b0;
        else if (fire)
            sent_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            sent_q <= 1'b0;
        else
            sent_q <= sent_d;
    end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequences one division at a time between the execute stage and
// the signed/unsigned divider IPs.
//   req_*          request channel from EXU (operands, signedness, quo/rem)
//   cancel         pipeline flush
//   resp_*         result channel back to EXU
//   busy           controller not idle
//   div_*_tdata    latched operands, shared by both IPs
//   sdiv_*/udiv_*  per-IP input valid/ready and result channels
// A flush after the IP has taken any operand goes through DRAIN so the
// orphaned result is swallowed instead of reaching a later instruction.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_signed,
    input  logic                  req_rem,
    input  logic [DATA_W-1:0]     req_dividend,
    input  logic [DATA_W-1:0]     req_divisor,
    input  logic                  cancel,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_result,
    output logic                  busy,
    output logic [DATA_W-1:0]     div_dividend_tdata,
    output logic [DATA_W-1:0]     div_divisor_tdata,
    output logic                  sdiv_dividend_tvalid,
    output logic                  sdiv_divisor_tvalid,
    input  logic                  sdiv_dividend_tready,
    input  logic                  sdiv_divisor_tready,
    input  logic                  sdiv_dout_tvalid,
    input  logic [2*DATA_W-1:0]   sdiv_dout_tdata,
    output logic                  udiv_dividend_tvalid,
    output logic                  udiv_divisor_tvalid,
    input  logic                  udiv_dividend_tready,
    input  logic                  udiv_divisor_tready,
    input  logic                  udiv_dout_tvalid,
    input  logic [2*DATA_W-1:0]   udiv_dout_tdata
);

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    dividend_q, dividend_d;
    logic [DATA_W-1:0]    divisor_q, divisor_d;
    logic                 signed_q, signed_d;
    logic                 rem_q, rem_d;
    logic [DATA_W-1:0]    result_q, result_d;

    logic                 accept;
    logic                 chan_active;
    logic                 dvd_tvalid, dvd_tready, dvd_sent, dvd_fire;
    logic                 dvs_tvalid, dvs_tready, dvs_sent, dvs_fire;
    logic                 dout_vld;
    logic [2*DATA_W-1:0]  dout_data;
    logic                 both_done;

    assign accept      = req_valid && req_ready;
    assign chan_active = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    // Counts a handshake completing this cycle as already sent.
    assign both_done   = (dvd_sent || dvd_fire) && (dvs_sent || dvs_fire);

    div_chan_hs u_dvd (
        .clk    (clk),
        .reset  (reset),
        .start  (accept),
        .active (chan_active),
        .tready (dvd_tready),
        .tvalid (dvd_tvalid),
        .sent   (dvd_sent),
        .fire   (dvd_fire)
    );

    div_chan_hs u_dvs (
        .clk    (clk),
        .reset  (reset),
        .start  (accept),
        .active (chan_active),
        .tready (dvs_tready),
        .tvalid (dvs_tvalid),
        .sent   (dvs_sent),
        .fire   (dvs_fire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            rem_q      <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            signed_q   <= signed_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        signed_d   = signed_q;
        rem_d      = rem_q;
        result_d   = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dividend_d = req_dividend;
                    divisor_d  = req_divisor;
                    signed_d   = req_signed;
                    rem_d      = req_rem;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cancel) begin
                    // Nothing reached the IP: safe to abandon outright.
                    if (!dvd_sent && !dvs_sent && !dvd_fire && !dvs_fire)
                        state_d = S_IDLE;
                    else
                        state_d = S_DRAIN;
                end else if (both_done) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cancel)
                    // A result arriving with the flush is already drained.
                    state_d = dout_vld ? S_IDLE : S_DRAIN;
                else if (dout_vld) begin
                    result_d = rem_q ? dout_data[REM_MSB:REM_LSB]
                                     : dout_data[QUO_MSB:QUO_LSB];
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (cancel || resp_ready)
                    state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (dvd_sent && dvs_sent && dout_vld)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and IP steering
    always_comb begin
        req_ready            = (state_q == S_IDLE) && !cancel;
        busy                 = (state_q != S_IDLE);
        resp_valid           = (state_q == S_DONE);
        resp_result          = result_q;
        div_dividend_tdata   = dividend_q;
        div_divisor_tdata    = divisor_q;
        sdiv_dividend_tvalid = signed_q && dvd_tvalid;
        sdiv_divisor_tvalid  = signed_q && dvs_tvalid;
        udiv_dividend_tvalid = !signed_q && dvd_tvalid;
        udiv_divisor_tvalid  = !signed_q && dvs_tvalid;
        dvd_tready           = signed_q ? sdiv_dividend_tready : udiv_dividend_tready;
        dvs_tready           = signed_q ? sdiv_divisor_tready  : udiv_divisor_tready;
        dout_vld             = signed_q ? sdiv_dout_tvalid     : udiv_dout_tvalid;
        dout_data            = signed_q ? sdiv_dout_tdata      : udiv_dout_tdata;
    end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

    localparam int W = 32;

    logic          clk, reset;
    logic          req_valid, req_ready, req_signed, req_rem;
    logic [W-1:0]  req_dividend, req_divisor;
    logic          cancel, resp_valid, resp_ready, busy;
    logic [W-1:0]  resp_result, div_dividend_tdata, div_divisor_tdata;
    logic          sdiv_dividend_tvalid, sdiv_divisor_tvalid;
    logic          sdiv_dividend_tready, sdiv_divisor_tready, sdiv_dout_tvalid;
    logic [2*W-1:0] sdiv_dout_tdata;
    logic          udiv_dividend_tvalid, udiv_divisor_tvalid;
    logic          udiv_dividend_tready, udiv_divisor_tready, udiv_dout_tvalid;
    logic [2*W-1:0] udiv_dout_tdata;

    int n_chk, n_fail;

    div_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_signed(req_signed), .req_rem(req_rem),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .cancel(cancel),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .busy(busy),
        .div_dividend_tdata(div_dividend_tdata), .div_divisor_tdata(div_divisor_tdata),
        .sdiv_dividend_tvalid(sdiv_dividend_tvalid), .sdiv_divisor_tvalid(sdiv_divisor_tvalid),
        .sdiv_dividend_tready(sdiv_dividend_tready), .sdiv_divisor_tready(sdiv_divisor_tready),
        .sdiv_dout_tvalid(sdiv_dout_tvalid), .sdiv_dout_tdata(sdiv_dout_tdata),
        .udiv_dividend_tvalid(udiv_dividend_tvalid), .udiv_divisor_tvalid(udiv_divisor_tvalid),
        .udiv_dividend_tready(udiv_dividend_tready), .udiv_divisor_tready(udiv_divisor_tready),
        .udiv_dout_tvalid(udiv_dout_tvalid), .udiv_dout_tdata(udiv_dout_tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          sg;
        logic          rm;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [2*W-1:0] dout;   // {quotient, remainder} the IP returns
        logic [W-1:0]  exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        req_valid = 0; req_signed = 0; req_rem = 0;
        req_dividend = '0; req_divisor = '0;
        cancel = 0; resp_ready = 0;
        sdiv_dividend_tready = 1; sdiv_divisor_tready = 1;
        udiv_dividend_tready = 1; udiv_divisor_tready = 1;
        sdiv_dout_tvalid = 0; sdiv_dout_tdata = '0;
        udiv_dout_tvalid = 0; udiv_dout_tdata = '0;
    endtask

    // Presents a request in IDLE; returns settled in the first ISSUE cycle.
    task automatic accept(input logic sg, input logic rm, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        req_valid = 1; req_signed = sg; req_rem = rm;
        req_dividend = a; req_divisor = b;
        settle();
        chk("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 0;
        settle();
    endtask

    task automatic drive_dout(input logic sg, input logic v, input logic [2*W-1:0] d);
        if (sg) begin sdiv_dout_tvalid = v; sdiv_dout_tdata = d; end
        else    begin udiv_dout_tvalid = v; udiv_dout_tdata = d; end
    endtask

    // From a settled ISSUE cycle with readies high: finish and consume result.
    task automatic complete(input logic sg, input logic [2*W-1:0] d, input logic [W-1:0] exp);
        tick();
        drive_dout(sg, 1, d);
        settle();
        tick();
        drive_dout(sg, 0, '0);
        settle();
        chk("resp_valid_done", resp_valid, 1);
        chk("resp_result", resp_result, exp);
        resp_ready = 1;
        settle();
        tick();
        resp_ready = 0;
        settle();
        chk("idle_after_resp", {resp_valid, busy}, 0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        vecs[0] = '{1, 0, 32'hFFFFFFF9, 32'd2,  {32'hFFFFFFFD, 32'hFFFFFFFF}, 32'hFFFFFFFD};
        vecs[1] = '{1, 1, 32'hFFFFFFF9, 32'd2,  {32'hFFFFFFFD, 32'hFFFFFFFF}, 32'hFFFFFFFF};
        vecs[2] = '{0, 0, 32'hFFFFFFFF, 32'd10, {32'h19999999, 32'h00000005}, 32'h19999999};
        vecs[3] = '{0, 1, 32'hFFFFFFFF, 32'd10, {32'h19999999, 32'h00000005}, 32'h00000005};
        vecs[4] = '{0, 0, 32'd100,      32'd0,  {32'hFFFFFFFF, 32'h00000064}, 32'hFFFFFFFF};
        vecs[5] = '{1, 1, 32'd100, 32'hFFFFFFF9, {32'hFFFFFFF2, 32'h00000002}, 32'h00000002};

        clear_in();
        reset = 1;
        tick(); tick();
        reset = 0;
        settle();
        chk("rst_busy_resp", {busy, resp_valid}, 0);
        chk("rst_result", resp_result, 0);
        chk("rst_tdata", {div_dividend_tdata, div_divisor_tdata}, 0);
        chk("rst_tvalids", {sdiv_dividend_tvalid, sdiv_divisor_tvalid,
                            udiv_dividend_tvalid, udiv_divisor_tvalid}, 0);

        // Table-driven operations, both readies high
        foreach (vecs[i]) begin
            accept(vecs[i].sg, vecs[i].rm, vecs[i].a, vecs[i].b);
            if (vecs[i].sg) begin
                chk("sel_tvalids", {sdiv_dividend_tvalid, sdiv_divisor_tvalid}, 2'b11);
                chk("unsel_tvalids", {udiv_dividend_tvalid, udiv_divisor_tvalid}, 0);
            end else begin
                chk("sel_tvalids", {udiv_dividend_tvalid, udiv_divisor_tvalid}, 2'b11);
                chk("unsel_tvalids", {sdiv_dividend_tvalid, sdiv_divisor_tvalid}, 0);
            end
            chk("tdata", {div_dividend_tdata, div_divisor_tdata}, {vecs[i].a, vecs[i].b});
            tick();
            chk("wait_tvalids", {sdiv_dividend_tvalid, sdiv_divisor_tvalid,
                                 udiv_dividend_tvalid, udiv_divisor_tvalid}, 0);
            chk("wait_busy", busy, 1);
            // Unselected IP result must be ignored
            drive_dout(!vecs[i].sg, 1, 64'hDEADBEEF_CAFEF00D);
            settle();
            tick();
            drive_dout(!vecs[i].sg, 0, '0);
            settle();
            chk("unsel_dout_ignored", resp_valid, 0);
            drive_dout(vecs[i].sg, 1, vecs[i].dout);
            settle();
            chk("no_resp_same_cycle", resp_valid, 0);
            tick();
            drive_dout(vecs[i].sg, 0, '0);
            settle();
            chk("resp_valid", resp_valid, 1);
            chk("resp_result_vec", resp_result, vecs[i].exp);
            resp_ready = 1;
            settle();
            tick();
            resp_ready = 0;
            settle();
            chk("idle_after", {resp_valid, busy}, 0);
        end

        // Staggered readies: divisor ready held off 3 cycles
        udiv_divisor_tready = 0;
        accept(0, 1, 32'hFFFFFFFF, 32'd10);
        chk("stag_c1", {udiv_dividend_tvalid, udiv_divisor_tvalid}, 2'b11);
        tick();
        udiv_dout_tvalid = 1; udiv_dout_tdata = 64'h12345678_9ABCDEF0; // ignored in ISSUE
        settle();
        chk("stag_c2", {udiv_dividend_tvalid, udiv_divisor_tvalid}, 2'b01);
        tick();
        udiv_dout_tvalid = 0;
        settle();
        chk("stag_c3", {udiv_dividend_tvalid, udiv_divisor_tvalid}, 2'b01);
        tick();
        udiv_divisor_tready = 1;
        settle();
        chk("stag_c4", {udiv_dividend_tvalid, udiv_divisor_tvalid}, 2'b01);
        chk("stag_no_resp", resp_valid, 0);
        tick();
        chk("stag_wait", {udiv_dividend_tvalid, udiv_divisor_tvalid}, 0);
        udiv_dout_tvalid = 1; udiv_dout_tdata = {32'h19999999, 32'h5};
        settle();
        tick();
        udiv_dout_tvalid = 0;
        settle();
        chk("stag_result", resp_result, 5);

        // Backpressure in DONE with a new request already waiting
        req_valid = 1; req_signed = 1; req_rem = 0;
        req_dividend = 32'hFFFFFFF9; req_divisor = 32'd2;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_valid_result", {resp_valid, resp_result}, {1'b1, 32'd5});
            chk("bp_req_ready", req_ready, 0);
            tick();
        end
        resp_ready = 1;
        settle();
        tick();
        resp_ready = 0;
        settle();
        chk("bp_idle", {resp_valid, req_ready}, 2'b01);
        tick();
        req_valid = 0;
        settle();
        chk("bp_new_issue", {sdiv_dividend_tvalid, sdiv_divisor_tvalid}, 2'b11);
        complete(1, {32'hFFFFFFFD, 32'hFFFFFFFF}, 32'hFFFFFFFD);

        // Cancel in WAIT, orphan result arrives 6 cycles later
        accept(1, 0, 32'd20, 32'd3);
        tick();
        cancel = 1;
        settle();
        tick();
        cancel = 0;
        settle();
        for (int i = 0; i < 5; i++) begin
            chk("drain_busy", {busy, resp_valid}, 2'b10);
            tick();
        end
        sdiv_dout_tvalid = 1; sdiv_dout_tdata = 64'hAAAAAAAA_BBBBBBBB;
        settle();
        chk("drain_dout_cycle_busy", busy, 1);
        tick();
        sdiv_dout_tvalid = 0;
        settle();
        chk("drain_done", {busy, resp_valid}, 0);
        accept(1, 0, 32'd20, 32'd3);
        complete(1, {32'd6, 32'd2}, 32'd6);

        // Cancel in ISSUE after only the dividend was sent
        udiv_divisor_tready = 0;
        accept(0, 0, 32'd50, 32'd7);
        tick();
        cancel = 1;
        settle();
        tick();
        cancel = 0;
        settle();
        chk("cis_drain_tv", {udiv_dividend_tvalid, udiv_divisor_tvalid, busy}, 3'b011);
        tick();
        udiv_divisor_tready = 1;
        settle();
        chk("cis_drain_hs", udiv_divisor_tvalid, 1);
        tick();
        chk("cis_sent", udiv_divisor_tvalid, 0);
        udiv_dout_tvalid = 1; udiv_dout_tdata = {32'd7, 32'd1};
        settle();
        tick();
        udiv_dout_tvalid = 0;
        settle();
        chk("cis_idle", {busy, resp_valid}, 0);

        // Cancel in ISSUE before any handshake
        udiv_dividend_tready = 0; udiv_divisor_tready = 0;
        accept(0, 0, 32'd1, 32'd1);
        cancel = 1;
        settle();
        chk("c0_tv", {udiv_dividend_tvalid, udiv_divisor_tvalid}, 2'b11);
        tick();
        cancel = 0; udiv_dividend_tready = 1; udiv_divisor_tready = 1;
        settle();
        chk("c0_idle", {busy, udiv_dividend_tvalid, udiv_divisor_tvalid}, 0);

        // Cancel in DONE drops the result
        accept(0, 0, 32'd9, 32'd3);
        tick();
        udiv_dout_tvalid = 1; udiv_dout_tdata = {32'd3, 32'd0};
        settle();
        tick();
        udiv_dout_tvalid = 0;
        settle();
        chk("cd_valid", resp_valid, 1);
        cancel = 1;
        settle();
        tick();
        cancel = 0;
        settle();
        chk("cd_dropped", {resp_valid, busy}, 0);

        // Reset mid-WAIT
        accept(1, 1, 32'd77, 32'd5);
        tick();
        reset = 1;
        tick();
        reset = 0;
        settle();
        chk("mrst_state", {busy, resp_valid}, 0);
        chk("mrst_result", resp_result, 0);
        chk("mrst_tdata", {div_dividend_tdata, div_divisor_tdata}, 0);
        chk("mrst_tv", {sdiv_dividend_tvalid, sdiv_divisor_tvalid}, 0);

        // Cancel concurrent with req_valid in IDLE
        req_valid = 1; cancel = 1; req_signed = 1;
        settle();
        chk("cidle_ready", req_ready, 0);
        tick();
        req_valid = 0; cancel = 0;
        settle();
        chk("cidle_state", {busy, sdiv_dividend_tvalid, sdiv_divisor_tvalid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
